// File: rtl/inst_queue.sv
// Instruction queue between fetch and decode: circular buffer that accepts up to two
// fetched instructions per cycle and presents the two oldest entries to decode.
package inst_queue_pkg;
    typedef logic [5:0] exception_t;
endpackage

module inst_queue
    import inst_queue_pkg::*;
#(
    parameter int DEPTH = 8  // power of two, >= 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    output logic             iq_ready,
    input  logic             if_a_valid,
    input  logic [31:0]      if_a_pc,
    input  logic [31:0]      if_a_inst,
    input  logic             if_a_pred_branch_taken,
    input  logic [31:0]      if_a_pred_branch_target,
    input  logic             if_a_have_exception,
    input  exception_t       if_a_exception_type,
    input  logic             if_b_valid,
    input  logic [31:0]      if_b_pc,
    input  logic [31:0]      if_b_inst,
    input  logic             if_b_pred_branch_taken,
    input  logic [31:0]      if_b_pred_branch_target,
    input  logic             if_b_have_exception,
    input  exception_t       if_b_exception_type,
    input  logic [1:0]       id_consume_inst,
    output logic             a_valid,
    output logic [31:0]      a_pc,
    output logic [31:0]      a_inst,
    output logic             a_pred_branch_taken,
    output logic [31:0]      a_pred_branch_target,
    output logic             a_have_exception,
    output exception_t       a_exception_type,
    output logic             b_valid,
    output logic [31:0]      b_pc,
    output logic [31:0]      b_inst,
    output logic             b_pred_branch_taken,
    output logic [31:0]      b_pred_branch_target,
    output logic             b_have_exception,
    output exception_t       b_exception_type
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        have_exc;
        exception_t  exc_type;
    } entry_t;

    entry_t            mem [DEPTH];
    logic [PTR_W-1:0]  head, tail;
    logic [PTR_W-1:0]  head_p1, tail_p1;
    logic [CNT_W-1:0]  count;
    logic              accept;
    logic [1:0]        enq_num, deq_req, deq_num;
    entry_t            slot_a, slot_b, wr0, ent_a, ent_b;

    // Handshake: fetch offers a pair every cycle; a pair is taken at the rising edge when
    // iq_ready && !flush. iq_ready depends only on the registered count, so it never
    // combinationally follows id_consume_inst.
    assign iq_ready = (count <= CNT_W'(DEPTH - 2));
    assign accept   = iq_ready && !flush;
    assign head_p1  = head + PTR_W'(1);
    assign tail_p1  = tail + PTR_W'(1);

    assign slot_a = '{pc: if_a_pc, inst: if_a_inst, pred_taken: if_a_pred_branch_taken,
                      pred_target: if_a_pred_branch_target, have_exc: if_a_have_exception,
                      exc_type: if_a_exception_type};
    assign slot_b = '{pc: if_b_pc, inst: if_b_inst, pred_taken: if_b_pred_branch_taken,
                      pred_target: if_b_pred_branch_target, have_exc: if_b_have_exception,
                      exc_type: if_b_exception_type};

    // Compaction: a lone valid b slot is written at tail just like a lone a slot.
    assign wr0 = if_a_valid ? slot_a : slot_b;

    always_comb begin
        enq_num = 2'd0;
        if (accept) enq_num = {1'b0, if_a_valid} + {1'b0, if_b_valid};
        deq_req = (id_consume_inst == 2'd3) ? 2'd0 : id_consume_inst;
        deq_num = (CNT_W'(deq_req) > count) ? count[1:0] : deq_req;
    end

    always_ff @(posedge clk) begin
        if (enq_num != 2'd0) mem[tail] <= wr0;
        if (enq_num == 2'd2) mem[tail_p1] <= slot_b;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_num);
            tail  <= tail + PTR_W'(enq_num);
            count <= count + CNT_W'(enq_num) - CNT_W'(deq_num);
        end
    end

    assign ent_a = mem[head];
    assign ent_b = mem[head_p1];

    // Slot data is forced to zero whenever the slot is empty, which also covers reset.
    always_comb begin
        a_valid              = (count >= CNT_W'(1));
        b_valid              = (count >= CNT_W'(2));
        a_pc                 = '0;
        a_inst               = '0;
        a_pred_branch_taken  = 1'b0;
        a_pred_branch_target = '0;
        a_have_exception     = 1'b0;
        a_exception_type     = '0;
        b_pc                 = '0;
        b_inst               = '0;
        b_pred_branch_taken  = 1'b0;
        b_pred_branch_target = '0;
        b_have_exception     = 1'b0;
        b_exception_type     = '0;
        if (a_valid) begin
            a_pc                 = ent_a.pc;
            a_inst               = ent_a.inst;
            a_pred_branch_taken  = ent_a.pred_taken;
            a_pred_branch_target = ent_a.pred_target;
            a_have_exception     = ent_a.have_exc;
            a_exception_type     = ent_a.exc_type;
        end
        if (b_valid) begin
            b_pc                 = ent_b.pc;
            b_inst               = ent_b.inst;
            b_pred_branch_taken  = ent_b.pred_taken;
            b_pred_branch_target = ent_b.pred_target;
            b_have_exception     = ent_b.have_exc;
            b_exception_type     = ent_b.exc_type;
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// Bench for inst_queue: a reference queue tracks every accepted fetch slot and is
// compared against both decode slots each cycle, plus directed scenario checks.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int W = 104;

    logic        clk;
    logic        resetn;
    logic        flush;
    logic        iq_ready;
    logic        if_a_valid, if_b_valid;
    logic [31:0] if_a_pc, if_b_pc, if_a_inst, if_b_inst;
    logic        if_a_pred_branch_taken, if_b_pred_branch_taken;
    logic [31:0] if_a_pred_branch_target, if_b_pred_branch_target;
    logic        if_a_have_exception, if_b_have_exception;
    exception_t  if_a_exception_type, if_b_exception_type;
    logic [1:0]  id_consume_inst;
    logic        a_valid, b_valid;
    logic [31:0] a_pc, b_pc, a_inst, b_inst;
    logic        a_pred_branch_taken, b_pred_branch_taken;
    logic [31:0] a_pred_branch_target, b_pred_branch_target;
    logic        a_have_exception, b_have_exception;
    exception_t  a_exception_type, b_exception_type;

    int n_checks = 0;
    int n_fail   = 0;
    bit mon_en   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] a_pack, b_pack;

    inst_queue #(.DEPTH(8)) dut (
        .clk(clk), .resetn(resetn), .flush(flush), .iq_ready(iq_ready),
        .if_a_valid(if_a_valid), .if_a_pc(if_a_pc), .if_a_inst(if_a_inst),
        .if_a_pred_branch_taken(if_a_pred_branch_taken),
        .if_a_pred_branch_target(if_a_pred_branch_target),
        .if_a_have_exception(if_a_have_exception), .if_a_exception_type(if_a_exception_type),
        .if_b_valid(if_b_valid), .if_b_pc(if_b_pc), .if_b_inst(if_b_inst),
        .if_b_pred_branch_taken(if_b_pred_branch_taken),
        .if_b_pred_branch_target(if_b_pred_branch_target),
        .if_b_have_exception(if_b_have_exception), .if_b_exception_type(if_b_exception_type),
        .id_consume_inst(id_consume_inst),
        .a_valid(a_valid), .a_pc(a_pc), .a_inst(a_inst),
        .a_pred_branch_taken(a_pred_branch_taken), .a_pred_branch_target(a_pred_branch_target),
        .a_have_exception(a_have_exception), .a_exception_type(a_exception_type),
        .b_valid(b_valid), .b_pc(b_pc), .b_inst(b_inst),
        .b_pred_branch_taken(b_pred_branch_taken), .b_pred_branch_target(b_pred_branch_target),
        .b_have_exception(b_have_exception), .b_exception_type(b_exception_type)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    assign a_pack = {a_pc, a_inst, a_pred_branch_taken, a_pred_branch_target,
                     a_have_exception, a_exception_type};
    assign b_pack = {b_pc, b_inst, b_pred_branch_taken, b_pred_branch_target,
                     b_have_exception, b_exception_type};

    // ---------------- reference model ----------------
    always @(posedge clk or negedge resetn) begin : model
        int sz;
        int d;
        bit rdy;
        if (!resetn || flush) begin
            exp_q.delete();
        end else begin
            sz  = exp_q.size();
            rdy = (8 - sz) >= 2;
            d   = (id_consume_inst == 2'd3) ? 0 : int'(id_consume_inst);
            if (d > sz) d = sz;
            repeat (d) void'(exp_q.pop_front());
            if (rdy && if_a_valid)
                exp_q.push_back({if_a_pc, if_a_inst, if_a_pred_branch_taken,
                                 if_a_pred_branch_target, if_a_have_exception, if_a_exception_type});
            if (rdy && if_b_valid)
                exp_q.push_back({if_b_pc, if_b_inst, if_b_pred_branch_taken,
                                 if_b_pred_branch_target, if_b_have_exception, if_b_exception_type});
        end
    end

    // ---------------- scoreboard compare ----------------
    always @(negedge clk) begin : monitor
        int sz;
        logic [W-1:0] ea, eb;
        if (mon_en) begin
            sz = exp_q.size();
            ea = (sz >= 1) ? exp_q[0] : '0;
            eb = (sz >= 2) ? exp_q[1] : '0;
            n_checks++;
            if (a_valid !== (sz >= 1)) begin
                n_fail++; $display("FAIL sb_a_valid: got %b want %b", a_valid, (sz >= 1));
            end
            n_checks++;
            if (b_valid !== (sz >= 2)) begin
                n_fail++; $display("FAIL sb_b_valid: got %b want %b", b_valid, (sz >= 2));
            end
            n_checks++;
            if (iq_ready !== (sz <= 6)) begin
                n_fail++; $display("FAIL sb_iq_ready: got %b want %b", iq_ready, (sz <= 6));
            end
            n_checks++;
            if (a_pack !== ea) begin
                n_fail++; $display("FAIL sb_a_entry: got %h want %h", a_pack, ea);
            end
            n_checks++;
            if (b_pack !== eb) begin
                n_fail++; $display("FAIL sb_b_entry: got %h want %h", b_pack, eb);
            end
            n_checks++;
            if (dut.count !== 4'(sz)) begin
                n_fail++; $display("FAIL sb_count: got %0d want %0d", dut.count, sz);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic set_fetch(input logic av, input logic [31:0] apc,
                             input logic bv, input logic [31:0] bpc);
        if_a_valid = av;  if_a_pc = apc;  if_a_inst = ~apc;
        if_a_pred_branch_taken = apc[3];  if_a_pred_branch_target = apc + 32'h100;
        if_a_have_exception = 1'b0;  if_a_exception_type = '0;
        if_b_valid = bv;  if_b_pc = bpc;  if_b_inst = ~bpc;
        if_b_pred_branch_taken = bpc[3];  if_b_pred_branch_target = bpc + 32'h100;
        if_b_have_exception = 1'b0;  if_b_exception_type = '0;
    endtask

    task automatic idle();
        set_fetch(1'b0, 32'h0, 1'b0, 32'h0);
        id_consume_inst = 2'd0;
        flush = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear();
        idle();
        flush = 1'b1;
        tick();
        flush = 1'b0;
    endtask

    task automatic fill_pairs(input int n, input logic [31:0] base);
        for (int i = 0; i < n; i++) begin
            set_fetch(1'b1, base + 32'(8 * i), 1'b1, base + 32'(8 * i + 4));
            tick();
        end
        idle();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle();
        resetn = 1'b1;
        #2 resetn = 1'b0;
        mon_en = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL reset_iq_ready: got %b want 1", iq_ready); end
        n_checks++;
        if ({a_valid, b_valid} !== 2'b00) begin n_fail++; $display("FAIL reset_valid: got %b want 00", {a_valid, b_valid}); end
        n_checks++;
        if ({a_pack, b_pack} !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", {a_pack, b_pack}); end
        @(posedge clk);
        #1 resetn = 1'b1;
    endtask

    task automatic test_basic();
        clear();
        set_fetch(1'b1, 32'h1c000000, 1'b1, 32'h1c000004);
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if ({a_valid, b_valid} !== 2'b11) begin n_fail++; $display("FAIL basic_valid: got %b want 11", {a_valid, b_valid}); end
        n_checks++;
        if (a_pc !== 32'h1c000000) begin n_fail++; $display("FAIL basic_a_pc: got %h want 1c000000", a_pc); end
        n_checks++;
        if (b_pc !== 32'h1c000004) begin n_fail++; $display("FAIL basic_b_pc: got %h want 1c000004", b_pc); end
        n_checks++;
        if (dut.count !== 4'd2) begin n_fail++; $display("FAIL basic_count: got %0d want 2", dut.count); end
    endtask

    task automatic test_full();
        clear();
        fill_pairs(4, 32'h2000_0000);
        @(negedge clk);
        n_checks++;
        if (iq_ready !== 1'b0) begin n_fail++; $display("FAIL full_iq_ready: got %b want 0", iq_ready); end
        set_fetch(1'b1, 32'hdead_0000, 1'b1, 32'hdead_0004);
        tick();
        tick();
        @(negedge clk);
        n_checks++;
        if (dut.count !== 4'd8) begin n_fail++; $display("FAIL full_ignored: got %0d want 8", dut.count); end
        idle();
        id_consume_inst = 2'd2;
        tick();
        id_consume_inst = 2'd0;
        @(negedge clk);
        n_checks++;
        if (iq_ready !== 1'b1) begin n_fail++; $display("FAIL full_drain_ready: got %b want 1", iq_ready); end
        n_checks++;
        if (a_pc !== 32'h2000_0008) begin n_fail++; $display("FAIL full_drain_a_pc: got %h want 20000008", a_pc); end
    endtask

    task automatic test_enq_deq();
        clear();
        set_fetch(1'b1, 32'h3000_0000, 1'b1, 32'h3000_0004);
        tick();
        set_fetch(1'b1, 32'h3000_0008, 1'b0, 32'h0);
        tick();
        set_fetch(1'b1, 32'h3000_000c, 1'b1, 32'h3000_0010);
        id_consume_inst = 2'd2;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (dut.count !== 4'd3) begin n_fail++; $display("FAIL enqdeq_count: got %0d want 3", dut.count); end
        n_checks++;
        if (a_pc !== 32'h3000_0008) begin n_fail++; $display("FAIL enqdeq_a_pc: got %h want 30000008", a_pc); end
    endtask

    task automatic test_underflow();
        clear();
        set_fetch(1'b0, 32'h0, 1'b1, 32'h4000_0004);
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (a_pc !== 32'h4000_0004) begin n_fail++; $display("FAIL compact_a_pc: got %h want 40000004", a_pc); end
        id_consume_inst = 2'd2;
        tick();
        id_consume_inst = 2'd0;
        @(negedge clk);
        n_checks++;
        if (dut.count !== 4'd0) begin n_fail++; $display("FAIL underflow_count: got %0d want 0", dut.count); end
        n_checks++;
        if (a_valid !== 1'b0) begin n_fail++; $display("FAIL underflow_a_valid: got %b want 0", a_valid); end
        n_checks++;
        if (dut.head !== 3'd1) begin n_fail++; $display("FAIL underflow_head: got %0d want 1", dut.head); end
        id_consume_inst = 2'd3;
        set_fetch(1'b1, 32'h4000_0008, 1'b0, 32'h0);
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (dut.count !== 4'd1) begin n_fail++; $display("FAIL consume3_count: got %0d want 1", dut.count); end
    endtask

    task automatic test_wrap();
        logic [31:0] base;
        clear();
        id_consume_inst = 2'd2;
        for (int i = 0; i < 10; i++) begin
            base = 32'h5000_0000 + 32'(16 * i);
            set_fetch(1'b1, base, 1'b1, base + 32'h4);
            if (i == 6) begin
                if_a_have_exception = 1'b1;
                if_a_exception_type = 6'h15;
            end
            tick();
            @(negedge clk);
            if (i == 6) begin
                n_checks++;
                if ({a_have_exception, a_exception_type, a_pc} !== {1'b1, 6'h15, base}) begin
                    n_fail++;
                    $display("FAIL wrap_exc: got %b/%h/%h want 1/15/%h", a_have_exception, a_exception_type, a_pc, base);
                end
            end
        end
        set_fetch(1'b0, 32'h0, 1'b0, 32'h0);
        repeat (2) tick();
        idle();
        @(negedge clk);
        n_checks++;
        if (dut.count !== 4'd0) begin n_fail++; $display("FAIL wrap_drain: got %0d want 0", dut.count); end
    endtask

    task automatic test_flush();
        clear();
        fill_pairs(3, 32'h6000_0000);
        set_fetch(1'b1, 32'h6100_0000, 1'b1, 32'h6100_0004);
        id_consume_inst = 2'd1;
        flush = 1'b1;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if ({dut.count, a_valid, b_valid, iq_ready} !== {4'd0, 3'b001}) begin
            n_fail++;
            $display("FAIL flush_state: got cnt=%0d av=%b bv=%b rdy=%b want 0/0/0/1", dut.count, a_valid, b_valid, iq_ready);
        end
        fill_pairs(2, 32'h6200_0000);
        flush = 1'b1;
        resetn = 1'b0;
        tick();
        @(negedge clk);
        n_checks++;
        if ({dut.count, a_valid, b_valid, iq_ready, a_pc} !== {4'd0, 3'b001, 32'h0}) begin
            n_fail++;
            $display("FAIL flush_reset: got cnt=%0d av=%b bv=%b rdy=%b pc=%h want 0/0/0/1/0", dut.count, a_valid, b_valid, iq_ready, a_pc);
        end
        @(posedge clk);
        #1;
        flush = 1'b0;
        resetn = 1'b1;
    endtask

    task automatic test_reset_mid();
        clear();
        fill_pairs(2, 32'h7000_0000);
        @(posedge clk);
        #2 resetn = 1'b0;
        #1;
        n_checks++;
        if ({a_valid, b_valid, iq_ready} !== 3'b001) begin
            n_fail++; $display("FAIL reset_mid: got %b want 001", {a_valid, b_valid, iq_ready});
        end
        @(posedge clk);
        #1;
        set_fetch(1'b1, 32'h7100_0000, 1'b0, 32'h0);
        resetn = 1'b1;
        tick();
        idle();
        @(negedge clk);
        n_checks++;
        if ({a_valid, a_pc} !== {1'b1, 32'h7100_0000}) begin
            n_fail++; $display("FAIL reset_first_enq: got %b/%h want 1/71000000", a_valid, a_pc);
        end
    endtask

    task automatic test_random();
        clear();
        for (int i = 0; i < 400; i++) begin
            set_fetch(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), $urandom);
            if_a_have_exception = 1'($urandom_range(0, 1));
            if_a_exception_type = 6'($urandom_range(0, 63));
            if_b_have_exception = 1'($urandom_range(0, 1));
            if_b_exception_type = 6'($urandom_range(0, 63));
            id_consume_inst = 2'($urandom_range(0, 3));
            flush = ($urandom_range(0, 40) == 0);
            tick();
        end
        idle();
        tick();
    endtask

    initial begin
        idle();
        resetn = 1'b1;
        test_reset();
        test_basic();
        test_full();
        test_enq_deq();
        test_underflow();
        test_wrap();
        test_flush();
        test_reset_mid();
        test_random();
        @(negedge clk);
        mon_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_queue.md
INST_QUEUE -- requirements
Module: inst_queue

Interface
REQ-001 The module SHALL have parameter DEPTH, default 8, meaning the number of entries; it SHALL be a power of two and at least 4.
REQ-002 clk  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 resetn  in  1  asynchronous, active-low reset.
REQ-004 flush  in  1  discard all queued entries (branch redirect or exception).
REQ-005 iq_ready  out  1  queue accepts a fetch pair this cycle.
REQ-006 if_a_valid / if_b_valid  in  1  fetch slot holds an instruction; a is older.
REQ-007 if_a_pc / if_b_pc  in  32  slot PC.
REQ-008 if_a_inst / if_b_inst  in  32  slot instruction word.
REQ-009 if_a_pred_branch_taken / if_b_pred_branch_taken  in  1  predictor taken bit.
REQ-010 if_a_pred_branch_target / if_b_pred_branch_target  in  32  predicted target.
REQ-011 if_a_have_exception / if_b_have_exception  in  1  fetch-side exception.
REQ-012 if_a_exception_type / if_b_exception_type  in  exception_t  fetch exception code.
REQ-013 id_consume_inst  in  2  number of entries the decode stage retires this cycle (0, 1 or 2).
REQ-014 a_valid, a_pc, a_inst, a_pred_branch_taken, a_pred_branch_target, a_have_exception, a_exception_type  out  1/32/32/1/32/1/exception_t  head entry to decode.
REQ-015 b_valid, b_pc, b_inst, b_pred_branch_taken, b_pred_branch_target, b_have_exception, b_exception_type  out  same widths  entry head+1 to decode.

Function
REQ-016 State SHALL be a circular buffer of DEPTH entries, head pointer, tail pointer (log2(DEPTH) bits, wrapping modulo DEPTH) and count (log2(DEPTH)+1 bits).
REQ-017 iq_ready SHALL equal (DEPTH - count >= 2), combinational from registered count only, with no dependence on id_consume_inst.
REQ-018 Enqueue SHALL occur when iq_ready && !flush; valid slots SHALL be compacted in order a then b: an invalid a with valid b writes b at tail.
REQ-019 Enqueue count SHALL be if_a_valid + if_b_valid; the tail SHALL advance by that amount.
REQ-020 When iq_ready is low, fetch inputs SHALL be ignored; fetch holds them until they are accepted.
REQ-021 Effective dequeue count SHALL be min(id_consume_inst, count); id_consume_inst = 3 SHALL be treated as 0. Head SHALL advance by the effective count.
REQ-022 Simultaneous enqueue and dequeue SHALL be legal; next count = count + enq - deq.
REQ-023 No bypass: an entry written in cycle N SHALL first appear on a_* or b_* in cycle N+1.
REQ-024 a_valid SHALL equal (count >= 1) and b_valid SHALL equal (count >= 2).
REQ-025 a_* fields SHALL come from entry[head] and b_* fields from entry[(head+1) mod DEPTH].
REQ-026 Each non-valid output field SHALL be driven to 0 when its slot valid is 0.
REQ-027 flush SHALL take priority over enqueue and dequeue: next cycle head = tail = count = 0, and fetch inputs in the flush cycle SHALL be dropped.
REQ-028 Storage SHALL preserve the order of every field, including exception bits; no entry SHALL be reordered, duplicated or lost.
REQ-029 Count SHALL never exceed DEPTH or underflow below 0 under any legal input.

Reset
REQ-030 While resetn = 0: head = tail = count = 0, a_valid = b_valid = 0, all a_*/b_* data outputs = 0, and iq_ready = 1.
REQ-031 Entry storage SHALL NOT be reset.
REQ-032 Reset asserted mid-operation SHALL discard all entries immediately. The first enqueue SHALL be accepted on the first rising edge after resetn deasserts.

Verification
REQ-033 Reset, then enqueue a pair pc=0x1c000000/0x1c000004, consume 0 → next cycle a_valid = b_valid = 1, a_pc = 0x1c000000, b_pc = 0x1c000004, count = 2.
REQ-034 Fill with 4 pairs (DEPTH = 8), consume 0 → iq_ready = 0 at count 8. Further fetch pairs are ignored. Then consume 2 → iq_ready = 1 next cycle.
REQ-035 Queue holds 3 entries, fetch pair enqueued, consume 2 in the same cycle → count = 3 next cycle, a_pc = third-oldest PC.
REQ-036 count = 1, id_consume_inst = 2 → count = 0, a_valid = 0, with no underflow and head advanced by 1.
REQ-037 Enqueue 10 pairs with continuous consume 2 → outputs follow fetch order across pointer wrap, with a_have_exception and a_exception_type preserved on the tagged entry.
REQ-038 Flush with count = 6 plus a valid fetch pair in the same cycle → next cycle count = 0, a_valid = b_valid = 0, iq_ready = 1. Flush asserted together with resetn low → reset values hold.
